// File: rtl/mac_seq_ctrl_if.sv
// Command, operand-stream and result handshake bundle for mac_seq_ctrl.
// The master side is the feeder/writeback logic; the slave side is the controller.
interface mac_seq_ctrl_if #(
    parameter int bw         = 4,
    parameter int psum_bw    = 16,
    parameter int input_size = 4,
    parameter int cnt_bw     = 8
);
    logic                       start;
    logic [cnt_bw-1:0]          len;
    logic                       busy;
    logic                       in_valid;
    logic                       in_ready;
    logic [bw*input_size-1:0]   a_in;
    logic [bw*input_size-1:0]   b_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [psum_bw-1:0]         out_psum;

    modport master (
        output start, len, in_valid, a_in, b_in, out_ready,
        input  busy, in_ready, out_valid, out_psum
    );

    modport slave (
        input  start, len, in_valid, a_in, b_in, out_ready,
        output busy, in_ready, out_valid, out_psum
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer that accumulates len beats of a 4-lane MAC (unsigned a x signed b)
// into a wrapping psum register and hands the result out on a valid/ready port.
module mac_seq_ctrl #(
    parameter int bw         = 4,
    parameter int psum_bw    = 16,
    parameter int input_size = 4,
    parameter int cnt_bw     = 8
) (
    input  logic             clk,
    input  logic             reset,
    mac_seq_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [psum_bw-1:0]  acc_q, acc_d;
    logic [cnt_bw-1:0]   cnt_q, cnt_d;
    logic [cnt_bw-1:0]   len_q, len_d;

    logic signed [bw:0]      a_ext [input_size];
    logic signed [bw-1:0]    b_s   [input_size];
    logic signed [2*bw:0]    prod  [input_size];
    logic [psum_bw-1:0]      lane  [input_size];
    logic [psum_bw-1:0]      dot;
    logic [psum_bw-1:0]      mac_out;

    // Activations are zero-extended so a full-scale unsigned value stays positive.
    always_comb begin
        for (int unsigned i = 0; i < input_size; i++) begin
            a_ext[i] = signed'({1'b0, bus.a_in[i*bw +: bw]});
            b_s[i]   = signed'(bus.b_in[i*bw +: bw]);
            prod[i]  = (2*bw+1)'(a_ext[i]) * (2*bw+1)'(b_s[i]);
            lane[i]  = psum_bw'(prod[i]);
        end
    end

    // Pairwise adder tree: (lane0+lane1) + (lane2+lane3); all sums wrap mod 2^psum_bw.
    always_comb begin
        dot = '0;
        for (int unsigned k = 0; k < input_size / 2; k++) begin
            dot = dot + (lane[2*k] + lane[2*k+1]);
        end
        if ((input_size % 2) != 0) begin
            dot = dot + lane[input_size-1];
        end
        mac_out = acc_q + dot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    len_d   = bus.len;
                    state_d = (bus.len != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                if (bus.in_valid) begin
                    acc_d = mac_out;
                    // Counter saturates at len_q-1 on the final beat instead of wrapping.
                    if (cnt_q == len_q - cnt_bw'(1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + cnt_bw'(1);
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_psum  = acc_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed self-checking bench for mac_seq_ctrl with hand-computed psum results.
module tb_mac_seq_ctrl;
    localparam int bw         = 4;
    localparam int psum_bw    = 16;
    localparam int input_size = 4;
    localparam int cnt_bw     = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl_if #(
        .bw(bw), .psum_bw(psum_bw), .input_size(input_size), .cnt_bw(cnt_bw)
    ) bus ();

    mac_seq_ctrl #(
        .bw(bw), .psum_bw(psum_bw), .input_size(input_size), .cnt_bw(cnt_bw)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_lanes(input logic [bw-1:0] a, input logic [bw-1:0] b);
        bus.a_in = {input_size{a}};
        bus.b_in = {input_size{b}};
    endtask

    // Pulse start at a negedge; len is scrambled afterwards to show it is latched.
    task automatic start_job(input logic [cnt_bw-1:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = ~n;
    endtask

    // Offer beats until n are accepted; returns the number of ACC cycles used.
    task automatic feed(input int n, input bit toggle, output int cyc);
        int got_n;
        got_n = 0;
        cyc   = 0;
        while (got_n < n && cyc < 1000) begin
            bus.in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (bus.in_valid && bus.in_ready) got_n++;
            cyc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (got_n < n) check("beat_timeout", got_n, n);
    endtask

    task automatic expect_done(input string tag, input logic [psum_bw-1:0] exp);
        check({tag, "_out_valid"}, bus.out_valid, 1'b1);
        check({tag, "_psum"}, bus.out_psum, exp);
        check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_idle_valid"}, bus.out_valid, 1'b0);
        check({tag, "_idle_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        int cyc;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_lanes('0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_psum", bus.out_psum, 16'h0000);

        // len=2, a=3, b=2: 6 per lane, 24 per beat, 48 total
        set_lanes(4'd3, 4'd2);
        start_job(8'd2);
        check("t1_busy", bus.busy, 1'b1);
        check("t1_in_ready", bus.in_ready, 1'b1);
        feed(2, 1'b0, cyc);
        check("t1_cycles", cyc, 2);
        expect_done("t1", 16'h0030);
        release_result("t1");

        // len=3, a=15, b=-1: -60 per beat, -180 total
        set_lanes(4'd15, 4'hF);
        start_job(8'd3);
        feed(3, 1'b0, cyc);
        expect_done("t2", 16'hFF4C);
        release_result("t2");

        // len=200, a=15, b=7: 420 per beat, 84000 wraps to 18464
        set_lanes(4'd15, 4'd7);
        start_job(8'd200);
        feed(200, 1'b0, cyc);
        check("t3_cycles", cyc, 200);
        expect_done("t3", 16'h4820);
        release_result("t3");

        // len=4, a=1, b=1, in_valid every other cycle: 16, last accept in cycle 7
        set_lanes(4'd1, 4'd1);
        start_job(8'd4);
        feed(4, 1'b1, cyc);
        check("t4_cycles", cyc, 7);
        expect_done("t4", 16'h0010);
        for (int k = 0; k < 5; k++) begin
            bus.start = (k % 2) == 0;
            bus.len   = 8'd9;
            @(negedge clk);
            check("t4_hold_valid", bus.out_valid, 1'b1);
            check("t4_hold_psum", bus.out_psum, 16'h0010);
        end
        // start together with out_ready must not launch a new job
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("t4_idle_valid", bus.out_valid, 1'b0);
        check("t4_idle_busy", bus.busy, 1'b0);
        @(negedge clk);
        check("t4_no_restart", bus.busy, 1'b0);

        // len=0: result 0 the next cycle, no beat accepted
        bus.in_valid = 1'b1;
        start_job(8'd0);
        expect_done("t5", 16'h0000);
        @(negedge clk);
        check("t5_hold_psum", bus.out_psum, 16'h0000);
        bus.in_valid = 1'b0;
        release_result("t5");

        // reset after 2 of 5 beats discards the job
        set_lanes(4'd1, 4'd1);
        start_job(8'd5);
        feed(2, 1'b0, cyc);
        check("t6_mid_busy", bus.busy, 1'b1);
        check("t6_mid_psum", bus.out_psum, 16'h0008);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_busy", bus.busy, 1'b0);
        check("t6_rst_valid", bus.out_valid, 1'b0);
        check("t6_rst_psum", bus.out_psum, 16'h0000);
        @(negedge clk);
        check("t6_rst_still_idle", bus.out_valid, 1'b0);
        start_job(8'd1);
        feed(1, 1'b0, cyc);
        expect_done("t6", 16'h0004);
        release_result("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
